// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the P5 MIPS core.
// Optional annul support is enabled by defining FETCH_FLUSH_EN (adds the flush input).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
`ifdef FETCH_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        j_en,
  input  logic        jr_en,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_val,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] id_pc4;
  logic [31:0] br_offset;
  logic        annul;

  assign im_addr   = pc;
  assign id_pc4    = id_pc + 32'd4;
  assign id_pc8    = id_pc + 32'd8;
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

`ifdef FETCH_FLUSH_EN
  assign annul = flush;
`else
  assign annul = 1'b0;
`endif

  // Redirects come from the instruction in ID, so targets are relative to id_pc.
  always_comb begin
    next_pc = pc + 32'd4;
    if (jr_en)
      next_pc = {rs_val[31:2], 2'b00};
    else if (j_en)
      next_pc = {id_pc4[31:28], index26, 2'b00};
    else if (br_taken)
      next_pc = id_pc4 + br_offset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      id_instr    <= NOP_WORD;
      id_pc       <= 32'd0;
      fetch_count <= 32'd0;
    end else if (!stall) begin
      pc    <= next_pc;
      id_pc <= pc;
      if (annul) begin
        id_instr <= NOP_WORD;
      end else begin
        id_instr    <= im_rdata;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven testbench for fetch_stage: redirects, stalls, wrap and async reset.
// Define FETCH_FLUSH_EN to also exercise the flush input.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic        j_en;
  logic        jr_en;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] rs_val;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic [31:0] fetch_count;
  logic        flush;

  int checks = 0;
  int failures = 0;

  fetch_stage dut (
`ifdef FETCH_FLUSH_EN
    .flush(flush),
`endif
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .br_taken(br_taken),
    .j_en(j_en),
    .jr_en(jr_en),
    .imm16(imm16),
    .index26(index26),
    .rs_val(rs_val),
    .im_addr(im_addr),
    .im_rdata(im_rdata),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_pc8(id_pc8),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br_taken;
    logic        j_en;
    logic        jr_en;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] rs_val;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_id_pc;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[15];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_id_pc, input logic [31:0] e_count);
    check_output({tag, " im_addr"}, im_addr, e_pc);
    check_output({tag, " id_instr"}, id_instr, e_instr);
    check_output({tag, " id_pc"}, id_pc, e_id_pc);
    check_output({tag, " id_pc8"}, id_pc8, e_id_pc + 32'd8);
    check_output({tag, " fetch_count"}, fetch_count, e_count);
  endtask

  task automatic apply_stimulus(input vec_t v);
    stall    = v.stall;
    br_taken = v.br_taken;
    j_en     = v.j_en;
    jr_en    = v.jr_en;
    imm16    = v.imm16;
    index26  = v.index26;
    rs_val   = v.rs_val;
    im_rdata = v.rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; br_taken = 1'b0; j_en = 1'b0; jr_en = 1'b0;
    imm16 = 16'h0; index26 = 26'h0; rs_val = 32'h0; im_rdata = 32'h0; flush = 1'b0;
  endtask

  initial begin
    // stall br j jr imm16 index26 rs_val rdata | pc instr id_pc count
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h0, 32'h3C01_1234, 32'h0000_3004, 32'h3C01_1234, 32'h0000_3000, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h0, 32'h3C01_1234, 32'h0000_3008, 32'h3C01_1234, 32'h0000_3004, 32'd2};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h0, 32'h2400_0002, 32'h0000_300C, 32'h2400_0002, 32'h0000_3008, 32'd3};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0000000, 32'h0, 32'h1000_0003, 32'h0000_3004, 32'h1000_0003, 32'h0000_300C, 32'd4};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h0, 32'hAAAA_0001, 32'h0000_3008, 32'hAAAA_0001, 32'h0000_3004, 32'd5};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 26'h0000C10, 32'h0, 32'hBBBB_0002, 32'h0000_3040, 32'hBBBB_0002, 32'h0000_3008, 32'd6};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0000000, 32'h0000_3055, 32'hCCCC_0003, 32'h0000_3054, 32'hCCCC_0003, 32'h0000_3040, 32'd7};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0004, 26'h0000C10, 32'h0000_4000, 32'hDDDD_0004, 32'h0000_4000, 32'hDDDD_0004, 32'h0000_3054, 32'd8};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 26'h0000000, 32'h0, 32'hEEEE_0005, 32'h0000_4000, 32'hDDDD_0004, 32'h0000_3054, 32'd8};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 26'h0000000, 32'h0, 32'hEEEE_0005, 32'h0000_4000, 32'hDDDD_0004, 32'h0000_3054, 32'd8};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 26'h0000000, 32'h0, 32'hEEEE_0005, 32'h0000_3098, 32'hEEEE_0005, 32'h0000_4000, 32'd9};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h8000, 26'h0000000, 32'h0, 32'h0000_0001, 32'hFFFE_4004, 32'h0000_0001, 32'h0000_3098, 32'd10};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0000000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFC, 32'h0000_0002, 32'hFFFE_4004, 32'd11};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0003, 32'hFFFF_FFFC, 32'd12};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 26'h3FFFFFF, 32'h0, 32'h0000_0004, 32'h0FFF_FFFC, 32'h0000_0004, 32'h0000_0000, 32'd13};

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0000_3000, 32'h0, 32'h0, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i]);
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_id_pc, vecs[i].exp_count);
    end

    // Async reset mid-stall with a pending branch, checked before any clock edge.
    stall = 1'b1; br_taken = 1'b1; imm16 = 16'h0040; im_rdata = 32'h1234_5678;
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 32'h0000_3000, 32'h0, 32'h0, 32'd0);
    @(posedge clk);
    #1;
    check_all("reset_held", 32'h0000_3000, 32'h0, 32'h0, 32'd0);
    clear_inputs();
    reset = 1'b0;

`ifdef FETCH_FLUSH_EN
    im_rdata = 32'h1111_0001;
    @(posedge clk);
    #1;
    check_all("pre_flush", 32'h0000_3004, 32'h1111_0001, 32'h0000_3000, 32'd1);
    flush = 1'b1; im_rdata = 32'h2222_0002;
    @(posedge clk);
    #1;
    check_all("flush", 32'h0000_3008, 32'h0, 32'h0000_3004, 32'd1);
    stall = 1'b1; im_rdata = 32'h3333_0003;
    @(posedge clk);
    #1;
    check_all("flush_stall", 32'h0000_3008, 32'h0, 32'h0000_3004, 32'd1);
    stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_flush", 32'h0000_300C, 32'h3333_0003, 32'h0000_3008, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the P5 pipelined MIPS core (instruction set: addu/subu/ori/lui/lw/sw/beq/j/jal/jr).
- Holds the PC, drives the instruction-memory address, and computes next-PC from redirects resolved in ID.
- Latches the fetched word into IF/ID; the ID-stage decoder consumes it directly.
- One architectural branch delay slot: the instruction after a branch or jump always executes.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- NOP_WORD, 32'h0000_0000, value loaded into id_instr on reset and flush.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  from hazard unit; freeze PC and IF/ID.
- br_taken  in  1  ID-stage beq resolved taken (Branch & equal).
- j_en  in  1  ID instruction is j or jal.
- jr_en  in  1  ID instruction is jr.
- imm16  in  16  ID instruction [15:0].
- index26  in  26  ID instruction [25:0].
- rs_val  in  32  forwarded GPR[rs] in ID.
- im_addr  out  32  instruction-memory word address, equal to current PC.
- im_rdata  in  32  instruction word, combinational read of im_addr.
- id_instr  out  32  IF/ID instruction register.
- id_pc  out  32  IF/ID PC of id_instr.
- id_pc8  out  32  id_pc + 8, link value for jal.
- fetch_count  out  32  number of instructions latched into IF/ID.

Behaviour:
- Async reset (posedge reset, any time, including mid-stall or mid-redirect): PC=RESET_PC, id_instr=NOP_WORD, id_pc=0, fetch_count=0. Combinational outputs follow: im_addr=RESET_PC, id_pc8=8.
- im_addr = PC (combinational). Low two bits are always 00.
- Next-PC priority, evaluated from ID-stage inputs:
  - jr_en: {rs_val[31:2],2'b00}.
  - else j_en: {id_pc4[31:28], index26, 2'b00}, where id_pc4 = id_pc + 4.
  - else br_taken: id_pc4 + ({{14{imm16[15]}}, imm16, 2'b00}).
  - else: PC + 4.
- All additions are 32-bit modulo 2^32. PC 0xFFFF_FFFC + 4 wraps to 0, with no flag.
- Redirects are relative to id_pc, not PC. The word already in IF (the delay slot) is still latched normally.
- Normal cycle (stall=0): PC <= next-PC; id_instr <= im_rdata; id_pc <= PC; fetch_count <= fetch_count + 1 (wraps).
- stall=1:
  - PC, id_instr, id_pc and fetch_count hold.
  - Redirect inputs are ignored that cycle. The ID instruction is held, so the redirect is re-presented on the first unstalled cycle.
- Latency: im_rdata at PC appears on id_instr one edge later. A redirect target is fetched the cycle after the redirect edge.
- Simultaneous j_en/jr_en/br_taken (illegal from decoder): the priority above applies; no error is raised.

Optional Feature:
- Macro FETCH_FLUSH_EN.
- When defined:
  - Adds input flush (1 bit).
  - flush=1 on an edge with stall=0: id_instr <= NOP_WORD, id_pc <= PC, fetch_count is not incremented, PC still updates to next-PC.
  - flush takes priority over normal latch. stall takes priority over flush: both high means hold.
  - Used for annul-on-not-taken or exception variants.
- When undefined: no flush port; delay slot always executes.

Test Plan:
- Reset released, im_rdata=32'h3C01_1234, no stall, 3 edges -> im_addr 3000→3004→3008→300C; after edge 1 id_instr=3C011234, id_pc=3000, id_pc8=3008; fetch_count=3.
- Reset asserted mid-run with stall=1 and br_taken=1 -> outputs immediately RESET_PC/NOP_WORD/0, with no clock needed.
- id_pc=3004, br_taken=1, imm16=16'hFFFE -> next PC=3000. The delay slot at 3008 is still latched into IF/ID.
- j_en=1, id_pc=3010, index26=26'h0000C10 -> PC=0000_3040. jr_en=1 with rs_val=0000_3055 -> PC=0000_3054. With jr_en and j_en both high, the jr target wins.
- stall=1 for 2 cycles with br_taken=1 -> PC, id_instr and fetch_count unchanged. On the release edge the PC takes the branch target.
- FETCH_FLUSH_EN defined: flush=1, stall=0 -> id_instr=0 and fetch_count unchanged. Flush=1 with stall=1 -> everything holds.
